scad_loop_unit: RTL

Parametrised shift-count/exponent datapath for the EBOX SCD area: a W-bit SCAD adder with A/B operand muxes, SC and FE registers, and a hardware count-down loop sequencer. The loop replaces microcode SC-decrement loops for shift, normalize and divide steps. It sits between the CRAM control fields and the AR/shift logic. Compared with the fixed 10-bit SCD datapath it has a configurable width, a configurable compare limit, and an autonomous loop with start/busy/done handshake.

---
 rtl/scad_loop_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/scad_loop_unit.sv
// ---------------------------------------------------------------------------
// scad_loop_unit
//
// Shift-count / exponent datapath for the EBOX SCD area. Contains the W-bit
// SCAD adder with its A/B operand muxes, the SC and FE registers, and a
// count-down loop sequencer. The sequencer replaces microcode SC-decrement
// loops for shift, normalize and divide steps.
//
// Parameters
//   W      width of SCAD, SC and FE (arithmetic mod 2^W, MSB is the sign)
//   LIMIT  signed threshold for sc_ge_limit_h, 0 < LIMIT < 2^(W-1)
//
// Ports
//   clk3_scd_h        clock, all state changes on the rising edge
//   mr_reset_01_h     synchronous active-high reset
//   cram_scada_sel_h  A operand: 0=FE 1=ar_exp 2=ar_pos 3=cram_nr
//   cram_scadb_sel_h  B operand: 0=SC 1=cram_nr 2=ar_exp 3=zero
//   cram_scad_op_h    0=A 1=A+B 2=A-B 3=A+1 4=A-1 5=A|B 6=A&B 7=B
//   cram_nr_h         microcode magic number
//   ar_exp_h          sign-extended exponent field from AR
//   ar_pos_h          position/size field from AR
//   sc_load_h         SC <- SCAD
//   fe_load_h         FE <- SCAD (live in every state)
//   loop_start_h      SC <- SCAD and start the count-down
//   loop_abort_h      terminate the loop without a done pulse
//   step_en_h         allow one loop decrement this cycle
//   scad_h            combinational SCAD result
//   sc_h, fe_h        registers
//   scd_scadEq0_l     low when scad_h is zero
//   scad_sign_h, sc_sign_h, fe_sign_h  sign bits
//   sc_ge_limit_h     signed SC >= LIMIT
//   loop_busy_h       high while the loop is running
//   loop_done_h       one-cycle completion pulse
// ---------------------------------------------------------------------------
module scad_loop_unit #(
  parameter int W     = 10,
  parameter int LIMIT = 36
) (
  input  logic         clk3_scd_h,
  input  logic         mr_reset_01_h,
  input  logic [1:0]   cram_scada_sel_h,
  input  logic [1:0]   cram_scadb_sel_h,
  input  logic [2:0]   cram_scad_op_h,
  input  logic [W-1:0] cram_nr_h,
  input  logic [W-1:0] ar_exp_h,
  input  logic [W-1:0] ar_pos_h,
  input  logic         sc_load_h,
  input  logic         fe_load_h,
  input  logic         loop_start_h,
  input  logic         loop_abort_h,
  input  logic         step_en_h,
  output logic [W-1:0] scad_h,
  output logic [W-1:0] sc_h,
  output logic [W-1:0] fe_h,
  output logic         scd_scadEq0_l,
  output logic         scad_sign_h,
  output logic         sc_sign_h,
  output logic         fe_sign_h,
  output logic         sc_ge_limit_h,
  output logic         loop_busy_h,
  output logic         loop_done_h
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE_W   = W'(1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  state_t       state_reg;
  logic [W-1:0] sc_reg;
  logic [W-1:0] fe_reg;
  logic         busy_reg;
  logic         done_reg;

  logic [W-1:0] scad_a;
  logic [W-1:0] scad_b;
  logic [W-1:0] scad_res;
  logic         scad_positive;

  // Operand muxes and SCAD function; all arithmetic wraps mod 2^W.
  always_comb begin
    scad_a = fe_reg;
    case (cram_scada_sel_h)
      2'd0: scad_a = fe_reg;
      2'd1: scad_a = ar_exp_h;
      2'd2: scad_a = ar_pos_h;
      2'd3: scad_a = cram_nr_h;
      default: scad_a = fe_reg;
    endcase

    scad_b = sc_reg;
    case (cram_scadb_sel_h)
      2'd0: scad_b = sc_reg;
      2'd1: scad_b = cram_nr_h;
      2'd2: scad_b = ar_exp_h;
      2'd3: scad_b = '0;
      default: scad_b = sc_reg;
    endcase

    scad_res = scad_a;
    case (cram_scad_op_h)
      3'd0: scad_res = scad_a;
      3'd1: scad_res = scad_a + scad_b;
      3'd2: scad_res = scad_a - scad_b;
      3'd3: scad_res = scad_a + ONE_W;
      3'd4: scad_res = scad_a - ONE_W;
      3'd5: scad_res = scad_a | scad_b;
      3'd6: scad_res = scad_a & scad_b;
      3'd7: scad_res = scad_b;
      default: scad_res = scad_a;
    endcase
  end

  // A loaded count only runs if it is strictly positive as a signed value.
  assign scad_positive = !scad_res[W-1] && (scad_res != '0);

  // Loop sequencer plus SC/FE registers. busy/done are registered copies of
  // the next state so they line up with the state without decode glitches.
  always_ff @(posedge clk3_scd_h) begin
    if (mr_reset_01_h) begin
      state_reg <= ST_IDLE;
      sc_reg    <= '0;
      fe_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      if (fe_load_h) begin
        fe_reg <= scad_res;
      end

      case (state_reg)
        ST_RUN: begin
          // The decrement still happens in an abort cycle, so SC is left
          // holding the number of iterations that were not executed.
          if (step_en_h) begin
            sc_reg <= sc_reg - ONE_W;
          end
          if (loop_abort_h) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end else if (step_en_h && (sc_reg == ONE_W)) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end

        default: begin
          // IDLE and DONE behave alike; DONE always falls back to IDLE
          // unless a new loop is started.
          if (loop_start_h && !loop_abort_h) begin
            sc_reg <= scad_res;
            if (scad_positive) begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b1;
              done_reg  <= 1'b0;
            end else begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end else begin
            // A start suppressed by abort must not sneak in through sc_load.
            if (sc_load_h && !loop_start_h) begin
              sc_reg <= scad_res;
            end
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign scad_h        = scad_res;
  assign sc_h          = sc_reg;
  assign fe_h          = fe_reg;
  assign scd_scadEq0_l = (scad_res != '0);
  assign scad_sign_h   = scad_res[W-1];
  assign sc_sign_h     = sc_reg[W-1];
  assign fe_sign_h     = fe_reg[W-1];
  assign sc_ge_limit_h = ($signed(sc_reg) >= $signed(LIMIT_W));
  assign loop_busy_h   = busy_reg;
  assign loop_done_h   = done_reg;

endmodule
